// File: rtl/k_and_s_pkg.sv
// Shared types and ALU op encodings for the K&S processor.
// Imported by the control unit and its branch-condition helper.
package k_and_s_pkg;

    typedef enum logic [4:0] {
        NOP,
        LOAD,
        STORE,
        MOVE,
        ADD,
        SUB,
        AND,
        OR,
        BRANCH,
        BZERO,
        BNZERO,
        BNEG,
        BNNEG,
        BOV,
        BNOV,
        BUS,
        BNUS,
        HALT
    } decoded_instruction_type;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        ALU,
        MEM,
        LOAD_WB,
        HALTED
    } ctrl_state_type;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_SUB = 2'b11;

    // MOVE falls through to OR: the datapath puts the source on both buses.
    function automatic logic [1:0] alu_op(
        input decoded_instruction_type ins
    );
        logic [1:0] op;
        op = OP_OR;
        case (ins)
            ADD:     op = OP_ADD;
            SUB:     op = OP_SUB;
            AND:     op = OP_AND;
            OR:      op = OP_OR;
            default: op = OP_OR;
        endcase
        return op;
    endfunction

    function automatic logic sets_flags(
        input decoded_instruction_type ins
    );
        logic f;
        f = 1'b0;
        case (ins)
            ADD, SUB, AND, OR: f = 1'b1;
            default:           f = 1'b0;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Conditional-branch evaluation for the K&S control unit.
// Purely combinational; unconditional and non-branch opcodes give 0.
module branch_cond
    import k_and_s_pkg::*;
(
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    is_cond,
    output logic                    taken
);

    always_comb begin
        is_cond = 1'b1;
        taken   = 1'b0;
        case (decoded_instruction)
            BZERO:   taken = zero_op;
            BNZERO:  taken = !zero_op;
            BNEG:    taken = neg_op;
            BNNEG:   taken = !neg_op;
            BOV:     taken = signed_overflow;
            BNOV:    taken = !signed_overflow;
            BUS:     taken = unsigned_overflow;
            BNUS:    taken = !unsigned_overflow;
            default: is_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute control FSM for the K&S processor.
// Drives every datapath strobe and the RAM write strobe from the state.
module control_unit
    import k_and_s_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    ctrl_state_type state;
    ctrl_state_type next_state;
    logic           cond_branch;
    logic           cond_taken;

    branch_cond u_branch_cond (
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .is_cond             (cond_branch),
        .taken               (cond_taken)
    );

    always_ff @(posedge clk) begin
        state <= next_state;
    end

    always_comb begin
        next_state       = state;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = OP_ADD;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;

        // Reset wins over every state and keeps all strobes low.
        if (rst) begin
            next_state = FETCH;
        end else begin
            unique case (state)
                FETCH: begin
                    ir_enable  = 1'b1;
                    next_state = DECODE;
                end
                DECODE: begin
                    next_state = FETCH;
                    pc_enable  = 1'b1;
                    if (cond_branch) begin
                        branch = cond_taken;
                    end else begin
                        case (decoded_instruction)
                            HALT: begin
                                pc_enable  = 1'b0;
                                next_state = HALTED;
                            end
                            ADD, SUB, AND, OR, MOVE: begin
                                next_state = ALU;
                            end
                            LOAD, STORE: begin
                                next_state = MEM;
                            end
                            BRANCH: begin
                                branch = 1'b1;
                            end
                            default: begin
                                next_state = FETCH;
                            end
                        endcase
                    end
                end
                ALU: begin
                    c_sel            = 1'b0;
                    write_reg_enable = 1'b1;
                    operation        = alu_op(decoded_instruction);
                    flags_reg_enable = sets_flags(decoded_instruction);
                    next_state       = FETCH;
                end
                MEM: begin
                    addr_sel = 1'b1;
                    if (decoded_instruction == STORE) begin
                        ram_write_enable = 1'b1;
                        next_state       = FETCH;
                    end else begin
                        next_state = LOAD_WB;
                    end
                end
                LOAD_WB: begin
                    addr_sel         = 1'b1;
                    c_sel            = 1'b1;
                    write_reg_enable = 1'b1;
                    next_state       = FETCH;
                end
                HALTED: begin
                    halt       = 1'b1;
                    next_state = HALTED;
                end
                default: begin
                    next_state = FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_unit.sv
// Directed-vector bench for control_unit.
// Each cycle's packed strobes are compared against hand-built values.
module tb_control_unit;
    import k_and_s_pkg::*;

    logic                    clk;
    logic                    rst;
    decoded_instruction_type decoded_instruction;
    logic                    zero_op;
    logic                    neg_op;
    logic                    unsigned_overflow;
    logic                    signed_overflow;
    logic                    branch;
    logic                    pc_enable;
    logic                    ir_enable;
    logic                    addr_sel;
    logic                    c_sel;
    logic [1:0]              operation;
    logic                    write_reg_enable;
    logic                    flags_reg_enable;
    logic                    ram_write_enable;
    logic                    halt;

    int n_vec;
    int n_bad;

    control_unit dut (
        .clk                 (clk),
        .rst                 (rst),
        .decoded_instruction (decoded_instruction),
        .zero_op             (zero_op),
        .neg_op              (neg_op),
        .unsigned_overflow   (unsigned_overflow),
        .signed_overflow     (signed_overflow),
        .branch              (branch),
        .pc_enable           (pc_enable),
        .ir_enable           (ir_enable),
        .addr_sel            (addr_sel),
        .c_sel               (c_sel),
        .operation           (operation),
        .write_reg_enable    (write_reg_enable),
        .flags_reg_enable    (flags_reg_enable),
        .ram_write_enable    (ram_write_enable),
        .halt                (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {branch,pc,ir,addr,csel,op[1:0],wr,flags,ramwr,halt}
    logic [10:0] outs;
    assign outs = {branch, pc_enable, ir_enable, addr_sel, c_sel,
                   operation, write_reg_enable, flags_reg_enable,
                   ram_write_enable, halt};

    function automatic logic [10:0] o(
        input logic b, input logic pc, input logic ir,
        input logic as, input logic cs, input logic [1:0] op,
        input logic wr, input logic fl, input logic rw,
        input logic h
    );
        return {b, pc, ir, as, cs, op, wr, fl, rw, h};
    endfunction

    logic [10:0] e_z, e_f, e_d, e_db, e_m, e_ms, e_lw, e_h;

    task automatic chk(input string tag, input logic [10:0] got,
                       input logic [10:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input string tag, input logic [10:0] e);
        chk(tag, outs, e);
        tick();
    endtask

    // Starts in FETCH; n cycles total, expectations after FETCH in e1..e3.
    task automatic run(input string tag, input decoded_instruction_type ins,
                       input logic [3:0] fl, input int n,
                       input logic [10:0] e1, input logic [10:0] e2,
                       input logic [10:0] e3);
        decoded_instruction = ins;
        {zero_op, neg_op, unsigned_overflow, signed_overflow} = fl;
        cyc({tag, "_fetch"}, e_f);
        cyc({tag, "_c1"}, e1);
        if (n > 2) cyc({tag, "_c2"}, e2);
        if (n > 3) cyc({tag, "_c3"}, e3);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        e_z  = '0;
        e_f  = o(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0);
        e_d  = o(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        e_db = o(1, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0);
        e_m  = o(0, 0, 0, 1, 0, 2'b00, 0, 0, 0, 0);
        e_ms = o(0, 0, 0, 1, 0, 2'b00, 0, 0, 1, 0);
        e_lw = o(0, 0, 0, 1, 1, 2'b00, 1, 0, 0, 0);
        e_h  = o(0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1);

        rst = 1'b1;
        decoded_instruction = ADD;
        {zero_op, neg_op, unsigned_overflow, signed_overflow} = 4'b0;
        #1;
        for (int i = 0; i < 3; i++) cyc("reset_hold", e_z);
        rst = 1'b0;
        #1;

        run("add", ADD, 4'b0000, 3, e_d,
            o(0, 0, 0, 0, 0, OP_ADD, 1, 1, 0, 0), e_z);
        run("sub", SUB, 4'b0000, 3, e_d,
            o(0, 0, 0, 0, 0, OP_SUB, 1, 1, 0, 0), e_z);
        run("and", AND, 4'b0000, 3, e_d,
            o(0, 0, 0, 0, 0, OP_AND, 1, 1, 0, 0), e_z);
        run("or", OR, 4'b0000, 3, e_d,
            o(0, 0, 0, 0, 0, OP_OR, 1, 1, 0, 0), e_z);
        run("move", MOVE, 4'b1111, 3, e_d,
            o(0, 0, 0, 0, 0, OP_OR, 1, 0, 0, 0), e_z);
        run("load", LOAD, 4'b0000, 4, e_d, e_m, e_lw);
        run("store", STORE, 4'b0000, 3, e_d, e_ms, e_z);
        run("nop", NOP, 4'b0000, 2, e_d, e_z, e_z);
        run("bzero_t", BZERO, 4'b1000, 2, e_db, e_z, e_z);
        run("bzero_n", BZERO, 4'b0111, 2, e_d, e_z, e_z);
        run("bnzero_t", BNZERO, 4'b0000, 2, e_db, e_z, e_z);
        run("bnus_t", BNUS, 4'b0000, 2, e_db, e_z, e_z);
        run("bnus_n", BNUS, 4'b0010, 2, e_d, e_z, e_z);
        run("bus_t", BUS, 4'b0010, 2, e_db, e_z, e_z);
        run("bneg_t", BNEG, 4'b0100, 2, e_db, e_z, e_z);
        run("bnneg_n", BNNEG, 4'b0100, 2, e_d, e_z, e_z);
        run("bov_t", BOV, 4'b0001, 2, e_db, e_z, e_z);
        run("bnov_n", BNOV, 4'b0001, 2, e_d, e_z, e_z);
        run("branch", BRANCH, 4'b0000, 2, e_db, e_z, e_z);
        run("unlisted", decoded_instruction_type'(5'd25), 4'b0000, 2,
            e_d, e_z, e_z);

        // Reset while in MEM of a LOAD: no write-back may follow.
        run("ld_rst", LOAD, 4'b0000, 2, e_d, e_z, e_z);
        chk("ld_rst_mem", outs, e_m);
        rst = 1'b1;
        #1;
        cyc("ld_rst_hold", e_z);
        rst = 1'b0;
        #1;
        run("after_rst", NOP, 4'b0000, 2, e_d, e_z, e_z);

        run("halt", HALT, 4'b1111, 2, e_z, e_z, e_z);
        for (int i = 0; i < 10; i++) cyc("halted", e_h);
        rst = 1'b1;
        #1;
        cyc("halt_rst", e_z);
        rst = 1'b0;
        #1;
        run("post_halt", ADD, 4'b0000, 3, e_d,
            o(0, 0, 0, 0, 0, OP_ADD, 1, 1, 0, 0), e_z);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
